// File: rtl/gray_convert_pipe.sv
// Pipelined binary/Gray converter: B2G, G2B and Gray increment with wrap flag.
// Latency 2 cycles from accept to out_valid, throughput 1 word per cycle.
// Full valid/ready backpressure; in_ready is combinational from out_ready (no skid buffer).
module gray_convert_pipe #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_mode,
  output logic                 out_wrap,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] txn_count
);

  localparam logic [1:0] MODE_B2G  = 2'd0;
  localparam logic [1:0] MODE_G2B  = 2'd1;
  localparam logic [1:0] MODE_GINC = 2'd2;

  // Stage 1: mode plus the binary form of the operand (raw data for B2G/reserved)
  logic             s1_vld_q;
  logic [1:0]       s1_mode_q;
  logic [WIDTH-1:0] s1_bin_q;
  logic [WIDTH-1:0] s1_bin_d;

  // Stage 2: registered result, drives the outputs directly
  logic             s2_vld_q;
  logic [WIDTH-1:0] s2_data_q;
  logic [1:0]       s2_mode_q;
  logic             s2_wrap_q;
  logic             s2_err_q;
  logic [WIDTH-1:0] s2_data_d;
  logic             s2_wrap_d;
  logic             s2_err_d;
  logic [WIDTH-1:0] ginc_n;

  logic [CNT_WIDTH-1:0] txn_q;

  logic s1_adv;
  logic in_acc;

  // S1 may move forward whenever S2 is empty or S2 is being drained this cycle
  assign s1_adv   = !s2_vld_q || out_ready;
  assign in_ready = !reset && (!s1_vld_q || s1_adv);
  assign in_acc   = in_valid && in_ready;

  // Gray-to-binary prefix XOR from the MSB down; other modes pass data through
  always_comb begin
    s1_bin_d = in_data;
    if (in_mode == MODE_G2B || in_mode == MODE_GINC) begin
      for (int i = WIDTH - 2; i >= 0; i--) begin
        s1_bin_d[i] = s1_bin_d[i+1] ^ in_data[i];
      end
    end
  end

  // Stage-2 result selection by mode; reserved mode echoes data and flags an error
  always_comb begin
    s2_data_d = s1_bin_q;
    s2_wrap_d = 1'b0;
    s2_err_d  = 1'b0;
    ginc_n    = s1_bin_q + WIDTH'(1);
    case (s1_mode_q)
      MODE_B2G:  s2_data_d = s1_bin_q ^ (s1_bin_q >> 1);
      MODE_G2B:  s2_data_d = s1_bin_q;
      MODE_GINC: begin
        s2_data_d = ginc_n ^ (ginc_n >> 1);
        s2_wrap_d = &s1_bin_q;
      end
      default:   s2_err_d  = 1'b1;
    endcase
  end

  // Stage-1 register: load on accept, otherwise empty once its word moves to S2
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= 2'd0;
      s1_bin_q  <= '0;
    end else if (in_acc) begin
      s1_vld_q  <= 1'b1;
      s1_mode_q <= in_mode;
      s1_bin_q  <= s1_bin_d;
    end else if (s1_adv) begin
      s1_vld_q  <= 1'b0;
    end
  end

  // Stage-2 register: take S1's word when advancing; held stable while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_mode_q <= 2'd0;
      s2_wrap_q <= 1'b0;
      s2_err_q  <= 1'b0;
    end else if (s1_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_data_q <= s2_data_d;
        s2_mode_q <= s1_mode_q;
        s2_wrap_q <= s2_wrap_d;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  // Accepted-word counter, wraps silently
  always_ff @(posedge clk) begin
    if (reset) begin
      txn_q <= '0;
    end else if (in_acc) begin
      txn_q <= txn_q + CNT_WIDTH'(1);
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_data_q;
  assign out_mode  = s2_mode_q;
  assign out_wrap  = s2_wrap_q;
  assign out_err   = s2_err_q;
  assign txn_count = txn_q;

endmodule
